// File: rtl/clic_irq_rx.sv
// CLIC interrupt receiver for one hart. It captures the presented interrupt, qualifies it
// against the hart's privilege, virtualization and threshold state, and runs the ready/kill_ack handshakes.
package clic_pkg;
    localparam int VSID_W = 6;
endpackage

module clic_irq_rx #(
    parameter int N_SOURCE   = 256,
    parameter int ID_W       = $clog2(N_SOURCE),
    parameter int INTCTLBITS = 8,
    parameter int VSID_W     = clic_pkg::VSID_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  irq_valid_i,
    output logic                  irq_ready_o,
    input  logic [ID_W-1:0]       irq_id_i,
    input  logic [INTCTLBITS-1:0] irq_level_i,
    input  logic                  irq_shv_i,
    input  logic [1:0]            irq_priv_i,
    input  logic                  irq_v_i,
    input  logic [VSID_W-1:0]     irq_vsid_i,
    input  logic                  irq_kill_req_i,
    output logic                  irq_kill_ack_o,
    input  logic [1:0]            core_priv_i,
    input  logic                  core_v_i,
    input  logic [VSID_W-1:0]     core_vsid_i,
    input  logic                  irq_enable_i,
    input  logic [INTCTLBITS-1:0] thresh_i,
    output logic                  take_valid_o,
    input  logic                  take_ready_i,
    output logic [ID_W-1:0]       take_id_o,
    output logic [INTCTLBITS-1:0] take_level_o,
    output logic                  take_shv_o,
    output logic [1:0]            take_priv_o,
    output logic                  take_v_o,
    output logic [VSID_W-1:0]     take_vsid_o,
    output logic [2**VSID_W-1:0]  vs_pending_o,
    output logic [CNT_W-1:0]      hold_cycles_o
);

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [INTCTLBITS-1:0] level;
        logic                  shv;
        logic [1:0]            priv;
        logic                  v;
        logic [VSID_W-1:0]     vsid;
    } irq_t;

    typedef enum logic [2:0] {IDLE, HOLD, OFFER, ACK, KACK} state_e;

    state_e           state_q, state_d;
    irq_t             held_q, held_d;
    logic             ack_kill_q, ack_kill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture;
    logic             held_act;
    logic             elig;

    assign capture  = (state_q == IDLE) && irq_valid_i && !irq_kill_req_i;
    assign held_act = (state_q == HOLD) || (state_q == OFFER);

    // A VS-tagged interrupt is only visible inside its own guest context.
    always_comb begin
        elig = 1'b0;
        if (held_q.v) begin
            elig = core_v_i && (core_vsid_i == held_q.vsid) &&
                   ((core_priv_i < held_q.priv) ||
                    ((core_priv_i == held_q.priv) && (held_q.level > thresh_i)));
        end else begin
            elig = (held_q.priv > core_priv_i) ||
                   (core_v_i && (held_q.priv >= 2'b01)) ||
                   ((held_q.priv == core_priv_i) && !core_v_i && (held_q.level > thresh_i));
        end
        elig = elig && irq_enable_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (irq_valid_i) state_d = irq_kill_req_i ? KACK : HOLD;
            end
            HOLD: begin
                if (irq_kill_req_i) state_d = KACK;
                else if (elig)      state_d = OFFER;
            end
            OFFER: begin
                if (take_ready_i)        state_d = ACK;
                else if (irq_kill_req_i) state_d = KACK;
                else if (!elig)          state_d = HOLD;
            end
            ACK:     state_d = IDLE;
            KACK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        take_valid_o   = (state_q == OFFER);
        irq_ready_o    = (state_q == ACK);
        irq_kill_ack_o = (state_q == KACK) || ((state_q == ACK) && ack_kill_q);
        vs_pending_o   = '0;
        if (held_act && held_q.v) vs_pending_o[held_q.vsid] = 1'b1;
    end

    // Take beats a simultaneous kill; the kill is still acknowledged alongside ready.
    always_comb begin
        held_d     = held_q;
        ack_kill_d = ack_kill_q;
        cnt_d      = cnt_q;
        if (capture) begin
            held_d = '{id: irq_id_i, level: irq_level_i, shv: irq_shv_i,
                       priv: irq_priv_i, v: irq_v_i, vsid: irq_vsid_i};
            cnt_d  = '0;
        end else if (held_act && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
        if ((state_q == OFFER) && take_ready_i) ack_kill_d = irq_kill_req_i;
        else if (state_q == ACK)                ack_kill_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            held_q     <= '0;
            ack_kill_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            held_q     <= held_d;
            ack_kill_q <= ack_kill_d;
            cnt_q      <= cnt_d;
        end
    end

    assign take_id_o     = held_q.id;
    assign take_level_o  = held_q.level;
    assign take_shv_o    = held_q.shv;
    assign take_priv_o   = held_q.priv;
    assign take_v_o      = held_q.v;
    assign take_vsid_o   = held_q.vsid;
    assign hold_cycles_o = cnt_q;

endmodule
